seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed hex digits (legal 1..8).
REQ-002 Parameter PRESCALE, default 1000, clock cycles each digit stays lit (legal >= 2).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port value  input  4*DIGITS  hex nibbles to display; nibble i = value[4i+3:4i], digit 0 least significant.
REQ-006 Port load  input  1  single-cycle request to capture value.
REQ-007 Port en  input  1  display enable; 0 blanks outputs, counters keep running.
REQ-008 Port abcdefg  output  7  segment drive, active-high, bit 6 = a ... bit 0 = g.
REQ-009 Port an  output  DIGITS  one-hot digit select, active-high.
REQ-010 Port frame_tick  output  1  one-cycle pulse when scan wraps to digit 0.
REQ-011 Port updated  output  1  one-cycle pulse when a captured value is committed to the display.

Function
REQ-012 Prescaler counts 0..PRESCALE-1, then wraps to 0; the digit index advances on each wrap.
REQ-013 Digit index counts 0..DIGITS-1 and wraps to 0; that wrap is the frame boundary.
REQ-014 Decode SHALL be full hex: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
REQ-015 abcdefg, an, frame_tick and updated SHALL be registered; each reflects the index, display register and enable of the previous cycle (1-cycle latency).
REQ-016 load=1 SHALL copy value into a pending register and set a pending flag.
REQ-017 A load while pending SHALL overwrite the pending value; the last load wins.
REQ-018 At a frame boundary with the pending flag set, the display register SHALL take the pending value, the flag SHALL clear, and updated SHALL pulse.
REQ-019 A load in the same cycle as a frame boundary SHALL commit that cycle's value directly at that boundary, and updated SHALL pulse.
REQ-020 A load mid-frame SHALL NOT change displayed digits before the next frame boundary; no tearing.
REQ-021 en=0 SHALL force an=0 and abcdefg=0; en SHALL NOT affect the prescaler, index, or load/commit path.
REQ-022 frame_tick SHALL pulse exactly once per DIGITS*PRESCALE cycles.
REQ-023 With DIGITS=1 the index stays 0, and every prescaler wrap is a frame boundary.

Reset
REQ-024 rst_n=0 SHALL immediately clear the prescaler, index, display register, pending register and pending flag, and force abcdefg=0, an=0, frame_tick=0, updated=0.
REQ-025 On the first rising clk edge after rst_n rises with en=1, the block SHALL output an=...0001 and abcdefg=7E.
REQ-026 Reset mid-frame or with a load pending SHALL discard the pending value; no updated pulse follows.

Configuration
REQ-027 Macro SEG7_LZ_SUPPRESS_EN defined: digit i>0 SHALL drive abcdefg=0 (an still selected) when it and all more significant digits are 0; digit 0 is never suppressed.
REQ-028 Macro SEG7_LZ_SUPPRESS_EN undefined: all digits SHALL be decoded, including leading zeros.

Verification (DIGITS=4, PRESCALE=4)
REQ-029 Release reset with en=1 -> an cycles 0001,0010,0100,1000 every 4 clk with abcdefg=7E; frame_tick every 16 clk.
REQ-030 load value=16'h1A2F mid-frame -> digits unchanged until the boundary; then updated pulses once and digits 0..3 show 47,6D,77,30.
REQ-031 load 16'h0003 then 16'h0005 in the same frame -> only 5B on digit 0 after the boundary; a single updated pulse.
REQ-032 load 16'hBEEF in the boundary cycle -> committed at that boundary; digit 0 shows 47 on the next slot.
REQ-033 en=0 for 10 clk -> an=0 and abcdefg=0; frame_tick period stays 16.
REQ-034 value 16'h0070 with SEG7_LZ_SUPPRESS_EN -> digits 3 and 2 show 00, digit 1 shows 70, digit 0 shows 7E; without the macro -> 7E,7E,70,7E; rst_n pulse mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bus between the seven-segment scan driver and its user: the display value and load
// request in, and the segment/anode drive plus frame and commit pulses out.
interface seg7_scan_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                en;
    logic [6:0]          abcdefg;
    logic [DIGITS-1:0]   an;
    logic                frame_tick;
    logic                updated;

    modport master (
        output value, load, en,
        input  abcdefg, an, frame_tick, updated
    );

    modport slave (
        input  value, load, en,
        output abcdefg, an, frame_tick, updated
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex seven-segment driver. A new value is committed only at a frame boundary.
// SEG7_LZ_SUPPRESS_EN: when defined, leading-zero digits above digit 0 are blanked.
module seg7_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    seg7_scan_if.slave bus
);
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;

    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic [VW-1:0]     r_disp;
    logic [VW-1:0]     r_pend;
    logic              r_pend_vld;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_an;
    logic              r_frame_tick;
    logic              r_updated;

    logic              w_presc_wrap;
    logic              w_idx_last;
    logic              w_frame;
    logic              w_commit;
    logic [PW-1:0]     w_presc_d;
    logic [IW-1:0]     w_idx_d;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [DIGITS-1:0] w_an;

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            4'hF: seg = 7'h47;
        endcase
        return seg;
    endfunction

    // Scan timing: prescaler wrap advances the digit, digit wrap is the frame boundary.
    always_comb begin
        w_presc_wrap = (r_presc == PW'(PRESCALE - 1));
        w_idx_last   = (r_idx == IW'(DIGITS - 1));
        w_frame      = w_presc_wrap && w_idx_last;
        w_commit     = w_frame && (bus.load || r_pend_vld);
        w_presc_d    = w_presc_wrap ? '0 : r_presc + 1'b1;
        w_idx_d      = r_idx;
        if (w_presc_wrap) begin
            w_idx_d = w_idx_last ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_presc_d;
            r_idx   <= w_idx_d;
        end
    end

    // A load coinciding with the boundary bypasses the pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else if (w_frame) begin
            if (bus.load) begin
                r_disp     <= bus.value;
                r_pend_vld <= 1'b0;
            end else if (r_pend_vld) begin
                r_disp     <= r_pend;
                r_pend_vld <= 1'b0;
            end
        end else if (bus.load) begin
            r_pend     <= bus.value;
            r_pend_vld <= 1'b1;
        end
    end

    always_comb begin
        w_nib   = 4'h0;
        w_blank = 1'b0;
        w_an    = DIGITS'(1) << r_idx;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib = r_disp[4*i +: 4];
`ifdef SEG7_LZ_SUPPRESS_EN
                if ((i > 0) && ((r_disp >> (4 * i)) == '0)) begin
                    w_blank = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= '0;
            r_an         <= '0;
            r_frame_tick <= 1'b0;
            r_updated    <= 1'b0;
        end else begin
            r_seg        <= (bus.en && !w_blank) ? hex2seg(w_nib) : '0;
            r_an         <= bus.en ? w_an : '0;
            r_frame_tick <= w_frame;
            r_updated    <= w_commit;
        end
    end

    assign bus.abcdefg    = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_tick = r_frame_tick;
    assign bus.updated    = r_updated;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver (DIGITS=4, PRESCALE=4) against a cycle-count model.
module tb_seg7_scan_driver;
    localparam int unsigned D = 4;
    localparam int unsigned P = 4;
    localparam logic [6:0] SegTab [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic clk = 1'b0;
    logic rst_n;
    seg7_scan_if #(.DIGITS(D)) bus ();

    seg7_scan_driver #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          n;          // clock edges since reset release
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pend_vld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input int idx);
        logic [3:0] nib;
        nib = m_disp[4*idx +: 4];
`ifdef SEG7_LZ_SUPPRESS_EN
        if (idx > 0 && (m_disp >> (4 * idx)) == 16'h0) return 7'h00;
`endif
        return SegTab[nib];
    endfunction

    // One clock: drive inputs, predict outputs after the edge, compare, advance model.
    task automatic cycle(input logic [15:0] v, input logic ld, input logic e);
        int         idx;
        logic       bnd;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_upd;
        bus.value = v;
        bus.load  = ld;
        bus.en    = e;
        idx   = (n / P) % D;
        bnd   = (n % (D * P)) == (D * P - 1);
        e_an  = e ? 4'(1 << idx) : 4'h0;
        e_seg = e ? model_seg(idx) : 7'h00;
        e_upd = bnd && (ld || m_pend_vld);
        @(posedge clk);
        #1;
        check("an", 32'(bus.an), 32'(e_an));
        check("abcdefg", 32'(bus.abcdefg), 32'(e_seg));
        check("frame_tick", 32'(bus.frame_tick), 32'(bnd));
        check("updated", 32'(bus.updated), 32'(e_upd));
        if (bnd) begin
            if (ld) begin
                m_disp     = v;
                m_pend_vld = 1'b0;
            end else if (m_pend_vld) begin
                m_disp     = m_pend;
                m_pend_vld = 1'b0;
            end
        end else if (ld) begin
            m_pend     = v;
            m_pend_vld = 1'b1;
        end
        n++;
    endtask

    task automatic run_n(input int k);
        for (int i = 0; i < k; i++) cycle(16'h0, 1'b0, 1'b1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_an", 32'(bus.an), 32'h0);
        check("rst_abcdefg", 32'(bus.abcdefg), 32'h0);
        check("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
        check("rst_updated", 32'(bus.updated), 32'h0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        n          = 0;
        m_disp     = 16'h0;
        m_pend     = 16'h0;
        m_pend_vld = 1'b0;
    endtask

    initial begin
        logic [6:0] exp_digits [4];
        logic [15:0] v;
        exp_digits = '{7'h47, 7'h6D, 7'h77, 7'h30};
        rst_n     = 1'b1;
        bus.value = '0;
        bus.load  = 1'b0;
        bus.en    = 1'b1;
        do_reset();

        // First edge after release shows digit 0 of zero.
        cycle(16'h0, 1'b0, 1'b1);
        check("first_an", 32'(bus.an), 32'h1);
        check("first_seg", 32'(bus.abcdefg), 32'h7E);
        run_n(20);                             // n = 21
        cycle(16'h1A2F, 1'b1, 1'b1);           // mid-frame load
        run_n(9);                              // n = 31, boundary next
        cycle(16'h0, 1'b0, 1'b1);
        check("upd_1a2f", 32'(bus.updated), 32'h1);
        for (int d = 0; d < 4; d++) begin
            cycle(16'h0, 1'b0, 1'b1);
            check("digit_1a2f", 32'(bus.abcdefg), 32'(exp_digits[d]));
            run_n(3);
        end
        run_n(15);                             // n = 63, boundary cycle
        cycle(16'hBEEF, 1'b1, 1'b1);
        check("upd_beef", 32'(bus.updated), 32'h1);
        cycle(16'h0, 1'b0, 1'b1);
        check("digit0_beef", 32'(bus.abcdefg), 32'h47);
        cycle(16'h0003, 1'b1, 1'b1);           // two loads, same frame
        cycle(16'h0005, 1'b1, 1'b1);
        run_n(12);                             // n = 79
        cycle(16'h0, 1'b0, 1'b1);
        cycle(16'h0, 1'b0, 1'b1);
        check("digit0_last_load", 32'(bus.abcdefg), 32'h5B);
        for (int i = 0; i < 10; i++) cycle(16'h0, 1'b0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & ($urandom_range(0, 1) ? 16'h000F : 16'h00F0);
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle(v, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
